micro_address_sequencer: RTL and testbench

Parametrised micro-program address sequencer for the control unit; generational successor of the micro address counter. Adds to the none/increment/reset/load commands: conditional branch, subroutine call/return through an internal return-address stack, and sticky stack error flags. Sits between the microcode ROM output decode and the microcode ROM address input. Address is registered, one update per clock.

---
 rtl/micro_address_sequencer.sv | 122 ++++++++++++
 tb/tb_micro_address_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/micro_address_sequencer.sv
// Micro-program address sequencer: registered micro address with increment, load,
// conditional branch and call/return through a return-address stack with sticky error flags.
module micro_address_sequencer #(
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH    = 4,
    parameter int unsigned INCREMENT_STEP = 1,
    parameter int unsigned RESET_ADDRESS  = 0,
    localparam int unsigned LevelWidth    = $clog2(STACK_DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [2:0]               command,
    input  logic                     condition,
    input  logic [ADDRESS_WIDTH-1:0] loadAddress,
    input  logic                     clearErrors,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic [LevelWidth-1:0]    stackLevel,
    output logic                     stackOverflow,
    output logic                     stackUnderflow
);

    localparam int unsigned IdxWidth = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] Step      = ADDRESS_WIDTH'(INCREMENT_STEP);
    localparam logic [ADDRESS_WIDTH-1:0] ResetAddr = ADDRESS_WIDTH'(RESET_ADDRESS);
    localparam logic [LevelWidth-1:0]    FullLevel = LevelWidth'(STACK_DEPTH);

    typedef enum logic [2:0] {
        CmdNone     = 3'd0,
        CmdInc      = 3'd1,
        CmdReset    = 3'd2,
        CmdLoad     = 3'd3,
        CmdBranch   = 3'd4,
        CmdCall     = 3'd5,
        CmdReturn   = 3'd6,
        CmdReserved = 3'd7
    } cmd_e;

    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [LevelWidth-1:0]    level_q, level_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic                     ovf_set, unf_set;

    logic [ADDRESS_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic                     push_en;
    logic [IdxWidth-1:0]      push_idx;
    logic [IdxWidth-1:0]      pop_idx;
    logic [ADDRESS_WIDTH-1:0] next_seq;
    cmd_e                     cmd;

    assign cmd      = cmd_e'(command);
    assign next_seq = addr_q + Step;
    assign push_idx = IdxWidth'(level_q);
    assign pop_idx  = IdxWidth'(level_q - LevelWidth'(1));

    always_comb begin
        addr_d  = addr_q;
        level_d = level_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        push_en = 1'b0;
        unique case (cmd)
            CmdNone: ;
            CmdInc:  addr_d = next_seq;
            CmdReset, CmdReserved: begin
                addr_d  = ResetAddr;
                level_d = '0;
            end
            CmdLoad:   addr_d = loadAddress;
            CmdBranch: addr_d = condition ? loadAddress : next_seq;
            CmdCall: begin
                if (level_q < FullLevel) begin
                    push_en = 1'b1;
                    level_d = level_q + LevelWidth'(1);
                    addr_d  = loadAddress;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            CmdReturn: begin
                if (level_q != '0) begin
                    addr_d  = stack_q[pop_idx];
                    level_d = level_q - LevelWidth'(1);
                end else begin
                    addr_d  = ResetAddr;
                    unf_set = 1'b1;
                end
            end
            default: ;
        endcase
        // A flag being set on this edge beats a simultaneous clear.
        ovf_d = (ovf_q & ~clearErrors) | ovf_set;
        unf_d = (unf_q & ~clearErrors) | unf_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= ResetAddr;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset: entries at or above level_q are never read.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_q[push_idx] <= next_seq;
        end
    end

    assign address        = addr_q;
    assign stackLevel     = level_q;
    assign stackOverflow  = ovf_q;
    assign stackUnderflow = unf_q;

endmodule

// File: tb/tb_micro_address_sequencer.sv
// Directed bench for micro_address_sequencer with default parameters (8-bit, depth 4).
module tb_micro_address_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] command = 3'd0;
    logic       condition = 1'b0;
    logic [7:0] loadAddress = 8'h00;
    logic       clearErrors = 1'b0;
    logic [7:0] address;
    logic [2:0] stackLevel;
    logic       stackOverflow;
    logic       stackUnderflow;

    int checks = 0;
    int errors = 0;

    micro_address_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .command        (command),
        .condition      (condition),
        .loadAddress    (loadAddress),
        .clearErrors    (clearErrors),
        .address        (address),
        .stackLevel     (stackLevel),
        .stackOverflow  (stackOverflow),
        .stackUnderflow (stackUnderflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one command for one rising edge, then sample 1 time unit later.
    task automatic step(input logic [2:0] c, input logic [7:0] la, input logic cond,
                        input logic clr);
        command     = c;
        loadAddress = la;
        condition   = cond;
        clearErrors = clr;
        @(posedge clock);
        #1;
        command     = 3'd0;
        clearErrors = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (address !== 8'h00 || stackLevel !== 3'd0 || stackOverflow !== 1'b0 ||
            stackUnderflow !== 1'b0)
            begin errors++; $display("FAIL reset_state: got %h/%0d/%b/%b want 00/0/0/0",
                address, stackLevel, stackOverflow, stackUnderflow); end
        @(negedge clock);
        reset = 1'b0;
        step(3'd3, 8'h55, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h55)
            begin errors++; $display("FAIL load_55: got %h want 55", address); end
        step(3'd0, 8'h99, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h55)
            begin errors++; $display("FAIL none_hold: got %h want 55", address); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (address !== 8'h00 || stackLevel !== 3'd0)
            begin errors++; $display("FAIL async_reset: got %h/%0d want 00/0",
                address, stackLevel); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_increment_branch();
        step(3'd3, 8'hFF, 1'b0, 1'b0);
        step(3'd1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h00)
            begin errors++; $display("FAIL inc_wrap: got %h want 00", address); end
        step(3'd1, 8'h00, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h01)
            begin errors++; $display("FAIL inc: got %h want 01", address); end
        step(3'd3, 8'h10, 1'b0, 1'b0);
        step(3'd4, 8'h80, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h11)
            begin errors++; $display("FAIL branch_not_taken: got %h want 11", address); end
        step(3'd4, 8'h80, 1'b1, 1'b0);
        checks++;
        if (address !== 8'h80)
            begin errors++; $display("FAIL branch_taken: got %h want 80", address); end
    endtask

    task automatic test_nested_call();
        logic [7:0] exp_a [4] = '{8'h40, 8'h60, 8'h41, 8'h11};
        logic [2:0] exp_l [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
        logic [2:0] cmds  [4] = '{3'd5, 3'd5, 3'd6, 3'd6};
        logic [7:0] tgts  [4] = '{8'h40, 8'h60, 8'h00, 8'h00};
        step(3'd3, 8'h10, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(cmds[i], tgts[i], 1'b0, 1'b0);
            checks++;
            if (address !== exp_a[i] || stackLevel !== exp_l[i])
                begin errors++; $display("FAIL nested_%0d: got %h/%0d want %h/%0d", i,
                    address, stackLevel, exp_a[i], exp_l[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] ret_a [4] = '{8'h31, 8'h31, 8'h31, 8'h21};
        step(3'd3, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'd5, 8'h30, 1'b0, 1'b0);
            checks++;
            if (address !== 8'h30 || stackLevel !== 3'(i + 1) || stackOverflow !== 1'b0)
                begin errors++; $display("FAIL call_%0d: got %h/%0d/%b want 30/%0d/0", i,
                    address, stackLevel, stackOverflow, i + 1); end
        end
        step(3'd5, 8'h77, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h30 || stackLevel !== 3'd4 || stackOverflow !== 1'b1)
            begin errors++; $display("FAIL overflow: got %h/%0d/%b want 30/4/1",
                address, stackLevel, stackOverflow); end
        for (int i = 0; i < 4; i++) begin
            step(3'd6, 8'h00, 1'b0, 1'b0);
            checks++;
            if (address !== ret_a[i] || stackLevel !== 3'(3 - i))
                begin errors++; $display("FAIL ovf_return_%0d: got %h/%0d want %h/%0d", i,
                    address, stackLevel, ret_a[i], 3 - i); end
        end
        checks++;
        if (stackOverflow !== 1'b1 || stackUnderflow !== 1'b0)
            begin errors++; $display("FAIL ovf_sticky: got %b/%b want 1/0",
                stackOverflow, stackUnderflow); end
        step(3'd0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (stackOverflow !== 1'b0 || address !== 8'h21)
            begin errors++; $display("FAIL ovf_clear: got %b/%h want 0/21",
                stackOverflow, address); end
    endtask

    task automatic test_underflow();
        step(3'd3, 8'h33, 1'b0, 1'b0);
        step(3'd6, 8'h00, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h00 || stackUnderflow !== 1'b1 || stackLevel !== 3'd0)
            begin errors++; $display("FAIL underflow: got %h/%b/%0d want 00/1/0",
                address, stackUnderflow, stackLevel); end
        step(3'd0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (stackUnderflow !== 1'b0)
            begin errors++; $display("FAIL unf_clear: got %b want 0", stackUnderflow); end
        step(3'd3, 8'h33, 1'b0, 1'b0);
        step(3'd6, 8'h00, 1'b0, 1'b1);
        checks++;
        if (stackUnderflow !== 1'b1 || address !== 8'h00)
            begin errors++; $display("FAIL set_beats_clear: got %b/%h want 1/00",
                stackUnderflow, address); end
    endtask

    task automatic test_reset_cmd();
        logic [2:0] rcmd [2] = '{3'd2, 3'd7};
        for (int i = 0; i < 2; i++) begin
            step(3'd3, 8'h10, 1'b0, 1'b0);
            step(3'd5, 8'h40, 1'b0, 1'b0);
            step(3'd5, 8'h50, 1'b0, 1'b0);
            step(rcmd[i], 8'hAA, 1'b0, 1'b0);
            checks++;
            if (address !== 8'h00 || stackLevel !== 3'd0 || stackUnderflow !== 1'b1 ||
                stackOverflow !== 1'b0)
                begin errors++; $display("FAIL reset_cmd_%0d: got %h/%0d/%b/%b want 00/0/1/0",
                    rcmd[i], address, stackLevel, stackUnderflow, stackOverflow); end
        end
        step(3'd0, 8'h00, 1'b0, 1'b1);
        step(3'd3, 8'h10, 1'b0, 1'b0);
        step(3'd5, 8'h40, 1'b0, 1'b0);
        step(3'd5, 8'h50, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        step(3'd6, 8'h00, 1'b0, 1'b0);
        checks++;
        if (address !== 8'h00 || stackUnderflow !== 1'b1 || stackLevel !== 3'd0)
            begin errors++; $display("FAIL reset_discards_stack: got %h/%b/%0d want 00/1/0",
                address, stackUnderflow, stackLevel); end
    endtask

    initial begin
        test_reset();
        test_increment_branch();
        test_nested_call();
        test_overflow();
        test_underflow();
        test_reset_cmd();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
